// File: rtl/median_pkg.sv
// Shared types and helpers for the 3x3 median filter controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default pixel width, sorted-column struct, controller state enum,
// scalar 3-input max/min/median helpers at the default pixel width.
package median_pkg;

  localparam int PIX_W_DEF = 8;

  typedef struct packed {
    logic [PIX_W_DEF-1:0] max;
    logic [PIX_W_DEF-1:0] med;
    logic [PIX_W_DEF-1:0] min;
  } sorted_col_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic [PIX_W_DEF-1:0] max3(input logic [PIX_W_DEF-1:0] a, b, c);
    logic [PIX_W_DEF-1:0] m;
    m = (a >= b) ? a : b;
    return (m >= c) ? m : c;
  endfunction

  function automatic logic [PIX_W_DEF-1:0] min3(input logic [PIX_W_DEF-1:0] a, b, c);
    logic [PIX_W_DEF-1:0] m;
    m = (a <= b) ? a : b;
    return (m <= c) ? m : c;
  endfunction

  function automatic logic [PIX_W_DEF-1:0] med3(input logic [PIX_W_DEF-1:0] a, b, c);
    logic [PIX_W_DEF-1:0] hi;
    logic [PIX_W_DEF-1:0] lo;
    hi = (a >= b) ? a : b;
    lo = (a >= b) ? b : a;
    if (c >= hi)      return hi;
    else if (c <= lo) return lo;
    else              return c;
  endfunction

endpackage

// File: rtl/med3_sort.sv
// Combinational 3-input unsigned sorter producing max, median and min.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers or holds the result.
// Ports: a_i/b_i/c_i operands; max_o/med_o/min_o sorted outputs.
module med3_sort
  import median_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic [PIX_W-1:0] a_i,
  input  logic [PIX_W-1:0] b_i,
  input  logic [PIX_W-1:0] c_i,
  output logic [PIX_W-1:0] max_o,
  output logic [PIX_W-1:0] med_o,
  output logic [PIX_W-1:0] min_o
);

  logic [PIX_W-1:0] hi_ab;
  logic [PIX_W-1:0] lo_ab;

  always_comb begin
    hi_ab = (a_i >= b_i) ? a_i : b_i;
    lo_ab = (a_i >= b_i) ? b_i : a_i;
    max_o = (hi_ab >= c_i) ? hi_ab : c_i;
    min_o = (lo_ab <= c_i) ? lo_ab : c_i;
    // c either lies above the pair, below it, or between them.
    if (c_i >= hi_ab)      med_o = hi_ab;
    else if (c_i <= lo_ab) med_o = lo_ab;
    else                   med_o = c_i;
  end

endmodule

// File: rtl/median_window_ctrl.sv
// Frame sequencer and 3-stage pipeline computing the 3x3 window median per interior pixel.
// Latency: 3 advancing cycles from a windowed column beat to out_valid_o; 1 result/cycle sustained.
// Backpressure: a stalled result freezes every stage and counter and drops in_ready_o.
// Ports: clk, rst_n (async active-low), start_i, in_valid_i/in_ready_o + col_top_i/col_mid_i/col_bot_i,
//        out_valid_o/out_ready_i + med_o/out_last_o, busy_o, done_o.
// Build option: MEDIAN_BYPASS_EN adds bypass_i, which replaces a beat's result by its centre pixel.
module median_window_ctrl
  import median_pkg::*;
#(
  parameter int PIX_W  = median_pkg::PIX_W_DEF,
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [PIX_W-1:0] col_top_i,
  input  logic [PIX_W-1:0] col_mid_i,
  input  logic [PIX_W-1:0] col_bot_i,
`ifdef MEDIAN_BYPASS_EN
  input  logic             bypass_i,
`endif
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [PIX_W-1:0] med_o,
  output logic             out_last_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef struct packed {
    logic [PIX_W-1:0] max;
    logic [PIX_W-1:0] med;
    logic [PIX_W-1:0] min;
  } col_t;

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  // Column history: h0 newest, h1 centre, h2 oldest.
  col_t              h0_q, h0_d, h1_q, h1_d, h2_q, h2_d;
  logic              s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
  logic [PIX_W-1:0]  s2_lo_q, s2_lo_d, s2_mi_q, s2_mi_d, s2_hi_q, s2_hi_d;
  logic              s2_vld_q, s2_vld_d, s2_last_q, s2_last_d;
  logic [PIX_W-1:0]  med_q, med_d;
  logic              out_vld_q, out_vld_d, out_last_q, out_last_d;
`ifdef MEDIAN_BYPASS_EN
  // Raw centre-row pixels of h0/h1, needed because the sorted columns lose position.
  logic [PIX_W-1:0]  raw0_q, raw0_d, raw1_q, raw1_d, s2_raw_q, s2_raw_d;
  logic              s1_byp_q, s1_byp_d, s2_byp_q, s2_byp_d;
`endif

  logic adv, in_xfer, out_xfer, col_end, row_end, win;
  col_t new_col;
  logic [PIX_W-1:0] lo_c, mi_c, hi_c, fin_med;
  logic [PIX_W-1:0] lo_nu0, lo_nu1, mi_nu0, mi_nu1, hi_nu0, hi_nu1, fin_nu0, fin_nu1;
  logic unused_sort_bits;

  med3_sort #(.PIX_W(PIX_W)) u_sort_col (
    .a_i(col_top_i), .b_i(col_mid_i), .c_i(col_bot_i),
    .max_o(new_col.max), .med_o(new_col.med), .min_o(new_col.min));

  // Window median = med3(max of mins, med of meds, min of maxes) over sorted columns.
  med3_sort #(.PIX_W(PIX_W)) u_sort_lo (
    .a_i(h0_q.min), .b_i(h1_q.min), .c_i(h2_q.min),
    .max_o(lo_c), .med_o(lo_nu0), .min_o(lo_nu1));
  med3_sort #(.PIX_W(PIX_W)) u_sort_mi (
    .a_i(h0_q.med), .b_i(h1_q.med), .c_i(h2_q.med),
    .max_o(mi_nu0), .med_o(mi_c), .min_o(mi_nu1));
  med3_sort #(.PIX_W(PIX_W)) u_sort_hi (
    .a_i(h0_q.max), .b_i(h1_q.max), .c_i(h2_q.max),
    .max_o(hi_nu0), .med_o(hi_nu1), .min_o(hi_c));
  med3_sort #(.PIX_W(PIX_W)) u_sort_fin (
    .a_i(s2_lo_q), .b_i(s2_mi_q), .c_i(s2_hi_q),
    .max_o(fin_nu0), .med_o(fin_med), .min_o(fin_nu1));

  assign unused_sort_bits = ^{lo_nu0, lo_nu1, mi_nu0, mi_nu1, hi_nu0, hi_nu1, fin_nu0, fin_nu1};

  always_comb begin
    adv        = !out_vld_q || out_ready_i;
    in_ready_o = (state_q == RUN) && adv;
    in_xfer    = in_valid_i && in_ready_o;
    out_xfer   = out_vld_q && out_ready_i;
    col_end    = (col_q == COL_W'(WIDTH - 1));
    row_end    = (row_q == ROW_W'(HEIGHT - 1));
    win        = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    h0_d       = h0_q;
    h1_d       = h1_q;
    h2_d       = h2_q;
    s1_vld_d   = s1_vld_q;
    s1_last_d  = s1_last_q;
    s2_lo_d    = s2_lo_q;
    s2_mi_d    = s2_mi_q;
    s2_hi_d    = s2_hi_q;
    s2_vld_d   = s2_vld_q;
    s2_last_d  = s2_last_q;
    med_d      = med_q;
    out_vld_d  = out_vld_q;
    out_last_d = out_last_q;
`ifdef MEDIAN_BYPASS_EN
    raw0_d     = raw0_q;
    raw1_d     = raw1_q;
    s2_raw_d   = s2_raw_q;
    s1_byp_d   = s1_byp_q;
    s2_byp_d   = s2_byp_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          col_d   = '0;
          row_d   = '0;
        end
      end
      RUN: begin
        if (in_xfer) begin
          col_d = col_end ? '0 : col_q + 1'b1;
          if (col_end) row_d = row_end ? '0 : row_q + 1'b1;
          if (col_end && row_end) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_xfer && out_last_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (adv) begin
      s1_vld_d  = in_xfer && win;
      s1_last_d = in_xfer && col_end && row_end;
      if (in_xfer) begin
        // First column of a row flushes stale history from the previous row.
        if (col_q == '0) begin
          h0_d = new_col;
          h1_d = new_col;
          h2_d = new_col;
        end else begin
          h0_d = new_col;
          h1_d = h0_q;
          h2_d = h1_q;
        end
      end
      s2_lo_d    = lo_c;
      s2_mi_d    = mi_c;
      s2_hi_d    = hi_c;
      s2_vld_d   = s1_vld_q;
      s2_last_d  = s1_last_q;
      med_d      = fin_med;
      out_vld_d  = s2_vld_q;
      out_last_d = s2_last_q;
`ifdef MEDIAN_BYPASS_EN
      if (in_xfer) begin
        s1_byp_d = bypass_i;
        raw0_d   = col_mid_i;
        raw1_d   = (col_q == '0) ? col_mid_i : raw0_q;
      end
      s2_raw_d = raw1_q;
      s2_byp_d = s1_byp_q;
      if (s2_byp_q) med_d = s2_raw_q;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      h0_q       <= '0;
      h1_q       <= '0;
      h2_q       <= '0;
      s1_vld_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_lo_q    <= '0;
      s2_mi_q    <= '0;
      s2_hi_q    <= '0;
      s2_vld_q   <= 1'b0;
      s2_last_q  <= 1'b0;
      med_q      <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
`ifdef MEDIAN_BYPASS_EN
      raw0_q     <= '0;
      raw1_q     <= '0;
      s2_raw_q   <= '0;
      s1_byp_q   <= 1'b0;
      s2_byp_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      h0_q       <= h0_d;
      h1_q       <= h1_d;
      h2_q       <= h2_d;
      s1_vld_q   <= s1_vld_d;
      s1_last_q  <= s1_last_d;
      s2_lo_q    <= s2_lo_d;
      s2_mi_q    <= s2_mi_d;
      s2_hi_q    <= s2_hi_d;
      s2_vld_q   <= s2_vld_d;
      s2_last_q  <= s2_last_d;
      med_q      <= med_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
`ifdef MEDIAN_BYPASS_EN
      raw0_q     <= raw0_d;
      raw1_q     <= raw1_d;
      s2_raw_q   <= s2_raw_d;
      s1_byp_q   <= s1_byp_d;
      s2_byp_q   <= s2_byp_d;
`endif
    end
  end

  assign med_o       = med_q;
  assign out_valid_o = out_vld_q;
  assign out_last_o  = out_last_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = out_xfer && out_last_q;

endmodule
